// File: rtl/skipring_ctl.sv
// skipring_ctl: builds an evenly spread skip mask serially and loads it into the clock-skip ring.
// Optional macro SKIPRING_CTL_AUTOLOAD_EN: a change of the clamped keep count while idle starts a sequence.
module skipring_ctl #(
  parameter int LEN = 16,
  parameter int CW  = 5,
  parameter int PW  = 4
) (
  input  logic           iCLK,
  input  logic           iRSTn,
  input  logic           iREQ,
  input  logic [CW-1:0]  iKEEP,
  input  logic [PW-1:0]  iPHASE,
  input  logic           iRUN,
  output logic [LEN-1:0] oSEL,
  output logic [LEN-1:0] oMASK,
  output logic           oRST,
  output logic           oE,
  output logic           oBUSY,
  output logic           oACK
);
  localparam int IW = $clog2(LEN);
  typedef enum logic [2:0] {IDLE, GEN, LOAD1, LOAD2, SETTLE} state_t;
  state_t         r_state;
  logic [CW-1:0]  r_acc, r_kc;
  logic [PW-1:0]  r_phase;
  logic [IW-1:0]  r_idx;
  logic [LEN-1:0] r_shadow;
  logic [CW:0]    w_sum;
  logic           w_keep, w_start;
  logic [CW-1:0]  w_acc, w_kc;
  logic [PW-1:0]  w_phase;
  logic [LEN-1:0] w_shadow;
  // Request clamping, Bresenham step and the shadow mask with the current bit merged in
  always_comb begin
    w_kc     = (32'(iKEEP) > LEN) ? CW'(LEN) : iKEEP;
    w_phase  = (32'(iPHASE) >= LEN) ? '0 : iPHASE;
    w_sum    = {1'b0, r_acc} + {1'b0, r_kc};
    w_keep   = w_sum >= (CW+1)'(LEN);
    w_acc    = w_keep ? CW'(w_sum - (CW+1)'(LEN)) : CW'(w_sum);
    w_shadow = r_shadow;
    w_shadow[r_idx] = ~w_keep;
`ifdef SKIPRING_CTL_AUTOLOAD_EN
    w_start  = iREQ || (w_kc != r_kc);
`else
    w_start  = iREQ;
`endif
  end
  // Sequencer: generate mask, hold load strobe two cycles so the ring samples stable values, then acknowledge
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_state  <= IDLE;
      oSEL     <= LEN'(1);
      oMASK    <= '0;
      oRST     <= 1'b0;
      oE       <= 1'b0;
      oBUSY    <= 1'b0;
      oACK     <= 1'b0;
      r_acc    <= '0;
      r_shadow <= '0;
      r_idx    <= '0;
      r_kc     <= CW'(LEN);
      r_phase  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          oE <= iRUN;
          if (w_start) begin
            r_kc    <= w_kc;
            r_phase <= w_phase;
            r_acc   <= '0;
            r_idx   <= '0;
            oBUSY   <= 1'b1;
            oE      <= 1'b0;
            r_state <= GEN;
          end
        end
        GEN: begin
          r_acc    <= w_acc;
          r_shadow <= w_shadow;
          r_idx    <= r_idx + 1'b1;
          if (r_idx == IW'(LEN-1)) begin
            oMASK   <= w_shadow;
            oSEL    <= LEN'(1) << r_phase;
            oRST    <= 1'b1;
            r_state <= LOAD1;
          end
        end
        LOAD1: r_state <= LOAD2;
        LOAD2: begin
          oRST    <= 1'b0;
          oACK    <= 1'b1;
          r_state <= SETTLE;
        end
        SETTLE: begin
          oACK    <= 1'b0;
          oBUSY   <= 1'b0;
          oE      <= iRUN;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_skipring_ctl.sv
// tb_skipring_ctl: scoreboard bench for skipring_ctl; expected loads queued at request, checked at oACK.
module tb_skipring_ctl;
  logic        iCLK = 1'b0, iRSTn = 1'b0, iREQ = 1'b0, iRUN = 1'b0;
  logic [4:0]  iKEEP = 5'd16;
  logic [3:0]  iPHASE = 4'd0;
  logic [15:0] oSEL, oMASK;
  logic        oRST, oE, oBUSY, oACK;
  int total = 0, bad = 0;
  typedef struct {logic [15:0] mask; logic [15:0] sel;} exp_t;
  exp_t sb[$];
  exp_t e_cur;
  logic [15:0] last_mask = '0;

  skipring_ctl dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iREQ(iREQ), .iKEEP(iKEEP), .iPHASE(iPHASE), .iRUN(iRUN),
    .oSEL(oSEL), .oMASK(oMASK), .oRST(oRST), .oE(oE), .oBUSY(oBUSY), .oACK(oACK)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic push(input logic [15:0] m, input int ph);
    exp_t e;
    e.mask = m;
    e.sel = 16'(1) << ph;
    sb.push_back(e);
  endtask

  always @(negedge iCLK) begin
    if (iRSTn && oACK === 1'b1) begin
      if (sb.size() == 0) chk("ack_unexpected", sb.size(), 1);
      else begin
        e_cur = sb.pop_front();
        chk("mask", oMASK, e_cur.mask);
        chk("sel", oSEL, e_cur.sel);
        last_mask = e_cur.mask;
      end
    end
  end

  task automatic run_seq(input int k, input int ph, input logic [15:0] em, input bit intf);
    push(em, ph);
    iKEEP = 5'(k);
    iPHASE = 4'(ph);
    iREQ = 1'b1;
    step();
    iREQ = 1'b0;
    chk("busy_start", oBUSY, 1);
    chk("e_off_start", oE, 0);
    for (int i = 1; i <= 15; i++) begin
      if (intf && i == 5) begin iREQ = 1'b1; iKEEP = 5'd2; iPHASE = 4'd7; end
      if (intf && i == 6) begin iREQ = 1'b0; iKEEP = 5'(k); iPHASE = 4'(ph); end
      step();
    end
    chk("mask_hold_gen", oMASK, last_mask);
    chk("rst_low_gen", oRST, 0);
    chk("e_off_gen", oE, 0);
    step();
    chk("rst_e16", oRST, 1);
    chk("busy_e16", oBUSY, 1);
    step();
    chk("rst_e17", oRST, 1);
    chk("ack_e17", oACK, 0);
    step();
    chk("rst_e18", oRST, 0);
    chk("ack_e18", oACK, 1);
    step();
    chk("ack_e19", oACK, 0);
    chk("busy_e19", oBUSY, 0);
    chk("e_e19", oE, iRUN);
  endtask

  initial begin
    int seen;
    repeat (2) @(posedge iCLK);
    #1;
    chk("rst_sel", oSEL, 16'h0001);
    chk("rst_mask", oMASK, 0);
    chk("rst_rst", oRST, 0);
    chk("rst_e", oE, 0);
    chk("rst_busy", oBUSY, 0);
    chk("rst_ack", oACK, 0);
    iRSTn = 1'b1;
    iRUN = 1'b1;
    step();
    chk("e_idle_on", oE, 1);
    iRUN = 1'b0;
    step();
    chk("e_idle_off", oE, 0);
    iRUN = 1'b1;
    step();
    run_seq(4, 0, 16'h7777, 0);
    run_seq(8, 3, 16'h5555, 0);
    run_seq(0, 5, 16'hFFFF, 0);
    run_seq(16, 0, 16'h0000, 0);
    run_seq(20, 9, 16'h0000, 0);
    run_seq(2, 15, 16'h7F7F, 0);
    run_seq(4, 0, 16'h7777, 1);
    iKEEP = 5'd4;
    iREQ = 1'b1;
    step();
    iREQ = 1'b0;
    repeat (7) step();
    iRSTn = 1'b0;
    #1;
    chk("abort_sel", oSEL, 16'h0001);
    chk("abort_mask", oMASK, 0);
    chk("abort_rst", oRST, 0);
    chk("abort_e", oE, 0);
    chk("abort_busy", oBUSY, 0);
    last_mask = '0;
    iKEEP = 5'd16;
    step();
    iRSTn = 1'b1;
    step();
    step();
    run_seq(8, 3, 16'h5555, 0);
    push(16'h7FFF, 0);
    push(16'h7FFF, 0);
    iKEEP = 5'd1;
    iPHASE = 4'd0;
    iREQ = 1'b1;
    repeat (20) step();
    chk("hold_idle_e19", oBUSY, 0);
    step();
    chk("hold_restart_e20", oBUSY, 1);
    iREQ = 1'b0;
    for (int i = 0; i < 30 && oBUSY; i++) step();
    chk("hold_done", oBUSY, 0);
`ifdef SKIPRING_CTL_AUTOLOAD_EN
    run_seq(16, 0, 16'h0000, 0);
    push(16'h5555, 0);
    iKEEP = 5'd8;
    step();
    chk("auto_start", oBUSY, 1);
    for (int i = 0; i < 30 && oBUSY; i++) step();
    chk("auto_done", oBUSY, 0);
    run_seq(16, 0, 16'h0000, 0);
    iKEEP = 5'd20;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 4) iKEEP = 5'd16;
      if (oBUSY) seen++;
    end
    chk("auto_none", seen, 0);
`endif
    repeat (3) step();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
